shift_add_multiplier: RTL

//   Sequential unsigned WIDTH x WIDTH multiplier built around one WIDTH-bit ripple adder.

---
 rtl/shift_add_multiplier_pkg.sv | 18 +
 rtl/shift_add_multiplier_four_bit_adder.sv | 24 ++
 rtl/shift_add_multiplier.sv | 101 ++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift/add multiplier: FSM state codes and default operand width.
package shift_add_multiplier_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef logic [1:0] state_t;

   localparam logic [1:0] STATE_IDLE  = 2'd0;
   localparam logic [1:0] STATE_ADD   = 2'd1;
   localparam logic [1:0] STATE_SHIFT = 2'd2;
   localparam logic [1:0] STATE_DONE  = 2'd3;

   // Busy covers the two states that are iterating over multiplier bits.
   function automatic logic state_is_busy(input state_t st);
      return (st == STATE_ADD) || (st == STATE_SHIFT);
   endfunction

endpackage

// File: rtl/shift_add_multiplier_four_bit_adder.sv
// Four-bit ripple-carry adder, time-shared by the multiplier datapath.
module shift_add_multiplier_four_bit_adder (
   input  logic       cin,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] carry;

   // Ripple the carry through four full-adder cells.
   always_comb begin
      carry    = 5'b0_0000;
      sum      = 4'b0000;
      carry[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      cout = carry[4];
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one conditional add and one right shift per multiplier bit,
// with a start/done handshake and a registered 2*WIDTH-bit product.
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

   state_t             state;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   m;
   logic               c;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;

   generate
      if (WIDTH == 4) begin : g_ripple
         shift_add_multiplier_four_bit_adder u_adder (
            .cin  (1'b0),
            .a    (a),
            .b    (m),
            .sum  (add_sum),
            .cout (add_cout)
         );
      end else begin : g_behav
         assign {add_cout, add_sum} = {1'b0, a} + {1'b0, m};
      end
   endgenerate

   assign busy = state_is_busy(state);
   assign done = (state == STATE_DONE);

   // Controller and datapath: operand load, conditional add, concatenated shift, result capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= STATE_IDLE;
         a       <= '0;
         q       <= '0;
         m       <= '0;
         c       <= 1'b0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            STATE_IDLE, STATE_DONE: begin
               if (start) begin
                  m     <= multiplicand;
                  q     <= multiplier;
                  a     <= '0;
                  c     <= 1'b0;
                  count <= COUNT_INIT;
                  state <= STATE_ADD;
               end else begin
                  state <= STATE_IDLE;
               end
            end
            STATE_ADD: begin
               if (q[0]) begin
                  a <= add_sum;
                  c <= add_cout;
               end else begin
                  c <= 1'b0;
               end
               state <= STATE_SHIFT;
            end
            STATE_SHIFT: begin
               // The carry of the last add drops into the accumulator MSB, so 15x15 cannot overflow.
               c     <= 1'b0;
               a     <= {c, a[WIDTH-1:1]};
               q     <= {a[0], q[WIDTH-1:1]};
               count <= count - COUNT_ONE;
               if (count == COUNT_ONE) begin
                  product <= {c, a, q[WIDTH-1:1]};
                  state   <= STATE_DONE;
               end else begin
                  state   <= STATE_ADD;
               end
            end
            default: begin
               state <= STATE_IDLE;
            end
         endcase
      end
   end

endmodule
